// File: rtl/gpu_net_if.sv
// GPU node network interface: TX FIFO toward the NoC link and a destination-filtered RX FIFO toward the core.
// Optional macro GPU_NI_BROADCAST_EN: also accept flits whose dest field is all-ones.

module gpu_net_if_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_full;
  logic         w_empty;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage has no reset: stale contents are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
endmodule

module gpu_net_if #(
  parameter int unsigned GPU_ID   = 2,
  parameter int unsigned FLIT_W   = 16,
  parameter int unsigned DEST_W   = 6,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [DEST_W-1:0]        tx_dest,
  input  logic [FLIT_W-DEST_W-1:0] tx_payload,
  output logic [FLIT_W-1:0]        net_data_out,
  output logic                     net_valid_out,
  input  logic                     net_ready_in,
  input  logic [FLIT_W-1:0]        net_data_in,
  input  logic                     net_valid_in,
  output logic                     net_ready_out,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [FLIT_W-DEST_W-1:0] rx_payload,
  output logic [7:0]               rx_drop_cnt
);
  localparam int unsigned PW = FLIT_W - DEST_W;
  localparam logic [DEST_W-1:0] MY_ID = DEST_W'(GPU_ID);

  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic [FLIT_W-1:0] w_tx_head;

  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic [PW-1:0]     w_rx_head;

  logic [DEST_W-1:0] w_in_dest;
  logic [PW-1:0]     w_in_payload;
  logic              w_accept;
  logic              w_match;
  logic              w_drop;
  logic [7:0]        r_drop_cnt;

  // TX path: the flit is stored pre-formatted so the link sees the head directly.
  assign w_tx_push = tx_valid && !w_tx_full;
  assign w_tx_pop  = !w_tx_empty && net_ready_in;

  gpu_net_if_fifo #(
    .W     (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_tx_push),
    .i_data  ({tx_dest, tx_payload}),
    .i_pop   (w_tx_pop),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_head  (w_tx_head)
  );

  assign tx_ready      = !w_tx_full;
  assign net_valid_out = !w_tx_empty;
  assign net_data_out  = w_tx_head;

  // RX path: every flit is gated by RX fullness, even those that end up dropped.
  assign w_in_dest    = net_data_in[FLIT_W-1 -: DEST_W];
  assign w_in_payload = net_data_in[PW-1:0];
  assign w_accept     = net_valid_in && !w_rx_full;

`ifdef GPU_NI_BROADCAST_EN
  assign w_match = (w_in_dest == MY_ID) || (w_in_dest == {DEST_W{1'b1}});
`else
  assign w_match = (w_in_dest == MY_ID);
`endif

  assign w_rx_push = w_accept && w_match;
  assign w_drop    = w_accept && !w_match;
  assign w_rx_pop  = !w_rx_empty && rx_ready;

  gpu_net_if_fifo #(
    .W     (PW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_rx_push),
    .i_data  (w_in_payload),
    .i_pop   (w_rx_pop),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (w_rx_head)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign net_ready_out = !w_rx_full;
  assign rx_valid      = !w_rx_empty;
  assign rx_payload    = w_rx_head;
  assign rx_drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_gpu_net_if.sv
// Directed bench for gpu_net_if: a per-cycle vector table plus hand sequences for saturation, reset and broadcast.
`timescale 1ns/1ps

module tb_gpu_net_if;
  logic        ACLK;
  logic        ARESETn;
  logic        tx_valid;
  logic        tx_ready;
  logic [5:0]  tx_dest;
  logic [9:0]  tx_payload;
  logic [15:0] net_data_out;
  logic        net_valid_out;
  logic        net_ready_in;
  logic [15:0] net_data_in;
  logic        net_valid_in;
  logic        net_ready_out;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  rx_payload;
  logic [7:0]  rx_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  gpu_net_if #(
    .GPU_ID   (2),
    .FLIT_W   (16),
    .DEST_W   (6),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_dest       (tx_dest),
    .tx_payload    (tx_payload),
    .net_data_out  (net_data_out),
    .net_valid_out (net_valid_out),
    .net_ready_in  (net_ready_in),
    .net_data_in   (net_data_in),
    .net_valid_in  (net_valid_in),
    .net_ready_out (net_ready_out),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_payload    (rx_payload),
    .rx_drop_cnt   (rx_drop_cnt)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    logic        tv;
    logic [5:0]  td;
    logic [9:0]  tp;
    logic        nri;
    logic        nvi;
    logic [15:0] ndi;
    logic        rr;
    logic        e_txr;
    logic        e_nvo;
    logic [15:0] e_ndo;
    logic        e_nro;
    logic        e_rxv;
    logic [9:0]  e_rxp;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int tv, input int td, input int tp, input int nri,
                              input int nvi, input int ndi, input int rr,
                              input int txr, input int nvo, input int ndo, input int nro,
                              input int rxv, input int rxp, input int cnt);
    vec_t v;
    v.tv = 1'(tv);   v.td = 6'(td);     v.tp = 10'(tp);   v.nri = 1'(nri);
    v.nvi = 1'(nvi); v.ndi = 16'(ndi);  v.rr = 1'(rr);
    v.e_txr = 1'(txr); v.e_nvo = 1'(nvo); v.e_ndo = 16'(ndo); v.e_nro = 1'(nro);
    v.e_rxv = 1'(rxv); v.e_rxp = 10'(rxp); v.e_cnt = 8'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input int txr, input int nvo, input int ndo, input int nro,
                          input int rxv, input int rxp, input int cnt);
    chk("tx_ready",      idx, 32'(tx_ready),      32'(txr));
    chk("net_valid_out", idx, 32'(net_valid_out), 32'(nvo));
    chk("net_data_out",  idx, 32'(net_data_out),  32'(ndo));
    chk("net_ready_out", idx, 32'(net_ready_out), 32'(nro));
    chk("rx_valid",      idx, 32'(rx_valid),      32'(rxv));
    chk("rx_payload",    idx, 32'(rx_payload),    32'(rxp));
    chk("rx_drop_cnt",   idx, 32'(rx_drop_cnt),   32'(cnt));
  endtask

  // Drive one cycle of inputs, let the edge pass, settle 1ns after it.
  task automatic step(input int tv, input int td, input int tp, input int nri,
                      input int nvi, input int ndi, input int rr);
    tx_valid = 1'(tv); tx_dest = 6'(td); tx_payload = 10'(tp); net_ready_in = 1'(nri);
    net_valid_in = 1'(nvi); net_data_in = 16'(ndi); rx_ready = 1'(rr);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    tx_valid = 0; tx_dest = 0; tx_payload = 0; net_ready_in = 0;
    net_valid_in = 0; net_data_in = 0; rx_ready = 0;
    ARESETn = 1'b0;

    //           tv td tp     nri nvi ndi     rr | txr nvo ndo     nro rxv rxp    cnt
    // Basic TX
    vecs.push_back(mk(1, 3, 'h123, 1, 0, 0,      0,  1, 1, 'h0D23, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 0, 0,      1, 0, 0,     0));
    // Back-pressure: fifth push refused, then four flits drain in order
    vecs.push_back(mk(1, 5, 1,     0, 0, 0,      0,  1, 1, 'h1401, 1, 0, 0,     0));
    vecs.push_back(mk(1, 5, 2,     0, 0, 0,      0,  1, 1, 'h1401, 1, 0, 0,     0));
    vecs.push_back(mk(1, 5, 3,     0, 0, 0,      0,  1, 1, 'h1401, 1, 0, 0,     0));
    vecs.push_back(mk(1, 5, 4,     0, 0, 0,      0,  0, 1, 'h1401, 1, 0, 0,     0));
    vecs.push_back(mk(1, 5, 5,     0, 0, 0,      0,  0, 1, 'h1401, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 1, 'h1402, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 1, 'h1403, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 1, 'h1404, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 0, 0,      1, 0, 0,     0));
    // Full with simultaneous pop refuses the push; push+pop keeps occupancy
    vecs.push_back(mk(1, 0, 'h0A,  0, 0, 0,      0,  1, 1, 'h000A, 1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 'h0B,  0, 0, 0,      0,  1, 1, 'h000A, 1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 'h0C,  0, 0, 0,      0,  1, 1, 'h000A, 1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 'h0D,  0, 0, 0,      0,  0, 1, 'h000A, 1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 'h0E,  1, 0, 0,      0,  1, 1, 'h000B, 1, 0, 0,     0));
    vecs.push_back(mk(1, 0, 'h0F,  1, 0, 0,      0,  1, 1, 'h000C, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 1, 'h000D, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 1, 'h000F, 1, 0, 0,     0));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      0,  1, 0, 0,      1, 0, 0,     0));
    // RX filter
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0955, 0,  1, 0, 0,      1, 1, 'h155, 0));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0D55, 0,  1, 0, 0,      1, 1, 'h155, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      1,  1, 0, 0,      1, 0, 0,     1));
    // RX full: refused flits (own and foreign) leave state and counter alone
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A01, 0,  1, 0, 0,      1, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A02, 0,  1, 0, 0,      1, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A03, 0,  1, 0, 0,      1, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A04, 0,  1, 0, 0,      0, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A05, 0,  1, 0, 0,      0, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0D55, 0,  1, 0, 0,      0, 1, 'h201, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A05, 1,  1, 0, 0,      1, 1, 'h202, 1));
    vecs.push_back(mk(0, 0, 0,     0, 1, 'h0A05, 0,  1, 0, 0,      0, 1, 'h202, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      1,  1, 0, 0,      1, 1, 'h203, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      1,  1, 0, 0,      1, 1, 'h204, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      1,  1, 0, 0,      1, 1, 'h205, 1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,      1,  1, 0, 0,      1, 0, 0,     1));
    // Both paths at once; TX to own ID goes out unchanged
    vecs.push_back(mk(1, 2, 'h3FF, 0, 1, 'h0955, 0,  1, 1, 'h0BFF, 1, 1, 'h155, 1));
    vecs.push_back(mk(0, 0, 0,     1, 0, 0,      1,  1, 0, 0,      1, 0, 0,     1));

    #12;
    chk_outs(-1, 1, 0, 0, 1, 0, 0, 0);
    ARESETn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].tv, vecs[i].td, vecs[i].tp, vecs[i].nri, vecs[i].nvi, vecs[i].ndi, vecs[i].rr);
      chk_outs(i, vecs[i].e_txr, vecs[i].e_nvo, vecs[i].e_ndo, vecs[i].e_nro,
               vecs[i].e_rxv, vecs[i].e_rxp, vecs[i].e_cnt);
      $display("[TB] vec %0d: tx_ready=%0d nvo=%0d ndo=0x%04h nro=%0d rxv=%0d rxp=0x%03h cnt=%0d",
               i, tx_ready, net_valid_out, net_data_out, net_ready_out, rx_valid, rx_payload, rx_drop_cnt);
    end

    // Drop counter saturation, starting from 1
    for (int k = 0; k < 300; k++) begin
      step(0, 0, 0, 0, 1, 'h0D55, 0);
      if (k == 99) chk("drop_cnt_100", 100, 32'(rx_drop_cnt), 32'd101);
    end
    chk("drop_cnt_sat", 300, 32'(rx_drop_cnt), 32'd255);
    $display("[TB] saturation: rx_drop_cnt=%0d", rx_drop_cnt);

    // Asynchronous reset mid-traffic
    step(1, 1, 'h111, 0, 1, 'h0955, 0);
    chk_outs(200, 1, 1, 'h0511, 1, 1, 'h155, 255);
    #2 ARESETn = 1'b0;
    #2;
    chk_outs(201, 1, 0, 0, 1, 0, 0, 0);
    $display("[TB] async reset: tx_ready=%0d nvo=%0d rxv=%0d cnt=%0d", tx_ready, net_valid_out, rx_valid, rx_drop_cnt);
    #2 ARESETn = 1'b1;
    step(0, 0, 0, 1, 0, 0, 1);
    chk_outs(202, 1, 0, 0, 1, 0, 0, 0);

    // Broadcast destination
    step(0, 0, 0, 0, 1, 'hFCAA, 0);
`ifdef GPU_NI_BROADCAST_EN
    chk_outs(300, 1, 0, 0, 1, 1, 'h0AA, 0);
`else
    chk_outs(300, 1, 0, 0, 1, 0, 0, 1);
`endif
    $display("[TB] broadcast: rxv=%0d rxp=0x%03h cnt=%0d", rx_valid, rx_payload, rx_drop_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
